// File: rtl/conv_window_if.sv
// Handshake bundle between the pixel source / MAC side and conv_window_ctrl.
// Carries win_cnt only when CONV_WIN_COUNT_EN is defined.
interface conv_window_if #(
    parameter int unsigned CNT_W = 6
);
    logic             start;
    logic             pix_valid;
    logic             pix_ready;
    logic             shift_en;
    logic             win_valid;
    logic             win_ready;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             busy;
    logic             done;
`ifdef CONV_WIN_COUNT_EN
    logic [15:0]      win_cnt;

    modport master (
        output start, pix_valid, win_ready,
        input  pix_ready, shift_en, win_valid, row, col, busy, done, win_cnt
    );
    modport slave (
        input  start, pix_valid, win_ready,
        output pix_ready, shift_en, win_valid, row, col, busy, done, win_cnt
    );
`else
    modport master (
        output start, pix_valid, win_ready,
        input  pix_ready, shift_en, win_valid, row, col, busy, done
    );
    modport slave (
        input  start, pix_valid, win_ready,
        output pix_ready, shift_en, win_valid, row, col, busy, done
    );
`endif
endinterface

// File: rtl/conv_window_ctrl.sv
// Sequencer for the KxK window register chain: shifts pixels in, flags complete windows,
// stalls the source until the MAC takes each window. CONV_WIN_COUNT_EN adds win_cnt.
module conv_window_ctrl #(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32,
    parameter int unsigned K     = 5,
    parameter int unsigned CNT_W = 6
) (
    input logic          clk_i,
    input logic          rst_ni,
    conv_window_if.slave ctrl_io
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [CNT_W-1:0] WinMin  = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] LastCol = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LastRow = CNT_W'(IMG_H - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             win_valid_q, win_valid_d;
    logic             pix_ready;
    logic             accept;
    logic             win_set;
    logic             last_pix;

    // The chain may only shift when the pending window leaves in the same cycle.
    assign pix_ready = (state_q == StLoad) & (~win_valid_q | ctrl_io.win_ready);
    assign accept    = ctrl_io.pix_valid & pix_ready;
    assign win_set   = accept & (row_q >= WinMin) & (col_q >= WinMin);
    assign last_pix  = accept & (row_q == LastRow) & (col_q == LastCol);

    always_comb begin
        win_valid_d = win_valid_q;
        if (win_set) begin
            win_valid_d = 1'b1;
        end else if (ctrl_io.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            StIdle: begin
                if (ctrl_io.start) begin
                    state_d = StLoad;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StLoad: begin
                if (last_pix) begin
                    state_d = StDrain;
                    row_d   = '0;
                    col_d   = '0;
                end else if (accept) begin
                    if (col_q == LastCol) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1);
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!win_valid_d) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign ctrl_io.pix_ready = pix_ready;
    assign ctrl_io.shift_en  = accept;
    assign ctrl_io.win_valid = win_valid_q;
    assign ctrl_io.row       = row_q;
    assign ctrl_io.col       = col_q;
    assign ctrl_io.busy      = (state_q == StLoad) | (state_q == StDrain);
    assign ctrl_io.done      = (state_q == StDone);

`ifdef CONV_WIN_COUNT_EN
    logic [15:0] win_cnt_q, win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if ((state_q == StIdle) && ctrl_io.start) begin
            win_cnt_d = '0;
        end else if (win_valid_q && ctrl_io.win_ready) begin
            win_cnt_d = win_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    assign ctrl_io.win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: pixel-index model checked every cycle plus directed frame scenarios.
module tb_conv_window_ctrl;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int KK   = 5;
    localparam int NPIX = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_if #(.CNT_W(6)) bus ();

    conv_window_ctrl #(
        .IMG_W(W),
        .IMG_H(H),
        .K    (KK),
        .CNT_W(6)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl_io(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: frame phase (0 idle, 1 load, 2 drain, 3 done), pixels taken, window pending.
    int m_phase = 0, m_acc = 0, m_win = 0, m_cnt = 0;
    int n_phase, n_acc, n_win, n_cnt;

    int cyc = 0, acc_cnt = 0, hs_cnt = 0, done_n = 0;
    int last_acc_cyc = 0, done_cyc = 0, first_win_acc = -1, seen_win = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [16:0] act, exp;
        logic        e_pr, e_se;
        int          p;
        bit          have_next = 0;
        @(negedge clk);
        if (rst_n) begin
            e_pr = (m_phase == 1) && (m_win == 0 || bus.win_ready);
            e_se = bus.pix_valid && e_pr;
            exp  = {e_pr, e_se, m_win != 0, m_phase == 1 || m_phase == 2, m_phase == 3,
                    6'((m_acc % NPIX) / W), 6'(m_acc % W)};
            act  = {bus.pix_ready, bus.shift_en, bus.win_valid, bus.busy, bus.done,
                    bus.row, bus.col};
            n_chk++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cycle %0d outputs {rdy,sh,wv,busy,done,row,col}: got %h, expected %h",
                         cyc, act, exp);
            end
`ifdef CONV_WIN_COUNT_EN
            chk("win_cnt per cycle", int'(bus.win_cnt), m_cnt);
`endif
            cyc++;
            if (bus.win_valid && !seen_win) begin
                seen_win      = 1;
                first_win_acc = acc_cnt;
            end
            if (bus.shift_en) begin
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (bus.win_valid && bus.win_ready) hs_cnt++;
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
                seen_win = 0;
            end
            n_phase = m_phase; n_acc = m_acc; n_win = m_win; n_cnt = m_cnt;
            if (m_win != 0 && bus.win_ready) begin
                n_win = 0;
                n_cnt = m_cnt + 1;
            end
            case (m_phase)
                0: if (bus.start) begin n_phase = 1; n_acc = 0; n_cnt = 0; end
                1: if (e_se) begin
                    p = m_acc;
                    if (p / W >= KK - 1 && p % W >= KK - 1) n_win = 1;
                    n_acc = m_acc + 1;
                    if (n_acc == NPIX) n_phase = 2;
                end
                2: if (n_win == 0) n_phase = 3;
                default: n_phase = 0;
            endcase
            have_next = 1;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_phase = 0; m_acc = 0; m_win = 0; m_cnt = 0; seen_win = 0;
        end else if (have_next) begin
            m_phase = n_phase; m_acc = n_acc; m_win = n_win; m_cnt = n_cnt;
        end
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_n;
        int i  = 0;
        while (done_n == d0 && i < budget) begin
            tick();
            i++;
        end
        chk({name, " done pulses"}, done_n - d0, 1);
    endtask

    int a0, h0;
    bit got;

    initial begin
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.win_ready = 1'b0;
        #1;
        tick();
        tick();
        chk("reset outputs", int'({bus.pix_ready, bus.shift_en, bus.win_valid, bus.busy,
                                   bus.done, bus.row, bus.col}), 0);
        rst_n = 1'b1;
        tick();

        // Full frame, source and MAC always ready; start issued with pix_valid already high.
        a0 = acc_cnt; h0 = hs_cnt;
        bus.pix_valid = 1'b1;
        bus.win_ready = 1'b1;
        pulse_start();
        wait_done("frame1", 1300);
        chk("frame1 shift_en pulses", acc_cnt - a0, 1024);
        chk("frame1 windows", hs_cnt - h0, 784);
        chk("frame1 first window after accept", first_win_acc - a0, 133);
        chk("frame1 done after last accept", done_cyc - last_acc_cyc, 2);
        repeat (3) tick();
`ifdef CONV_WIN_COUNT_EN
        chk("win_cnt holds in idle", int'(bus.win_cnt), 784);
`endif

        // MAC stalls for 10 cycles on the first window.
        a0 = acc_cnt; h0 = hs_cnt;
        pulse_start();
`ifdef CONV_WIN_COUNT_EN
        chk("win_cnt cleared by start", int'(bus.win_cnt), 0);
`endif
        got = 0;
        for (int i = 0; i < 300 && !bus.win_valid; i++) tick();
        chk("stall first window reached", int'(bus.win_valid), 1);
        for (int i = 0; i < 10; i++) begin
            bus.win_ready = 1'b0;
            #3;
            chk("stall pix_ready", int'(bus.pix_ready), 0);
            chk("stall shift_en", int'(bus.shift_en), 0);
            chk("stall win_valid held", int'(bus.win_valid), 1);
            tick();
        end
        bus.win_ready = 1'b1;
        #3;
        chk("unstall pix_ready", int'(bus.pix_ready), 1);
        chk("unstall shift_en", int'(bus.shift_en), 1);
        tick();
        wait_done("stall frame", 1300);
        chk("stall frame shifts", acc_cnt - a0, 1024);
        chk("stall frame windows", hs_cnt - h0, 784);

        // Source toggles valid every cycle.
        a0 = acc_cnt; h0 = hs_cnt;
        bus.pix_valid = 1'b0;
        pulse_start();
        got = 0;
        for (int i = 0; i < 2600 && done_n == 0 + done_n && !got; i++) begin
            bus.pix_valid = ~bus.pix_valid;
            tick();
            if (acc_cnt - a0 == 64) begin
                got = 1;
                chk("toggle row after 64", int'(bus.row), 2);
                chk("toggle col after 64", int'(bus.col), 0);
            end
        end
        chk("toggle reached 64 accepts", int'(got), 1);
        bus.pix_valid = 1'b1;
        wait_done("toggle frame", 1300);
        chk("toggle frame windows", hs_cnt - h0, 784);

        // Reset asserted mid-frame at accept #500.
        a0 = acc_cnt;
        pulse_start();
        for (int i = 0; i < 1000 && (acc_cnt - a0) != 499; i++) tick();
        chk("pre-reset row", int'(bus.row), 15);
        chk("pre-reset col", int'(bus.col), 19);
        chk("pre-reset shift_en", int'(bus.shift_en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", int'({bus.pix_ready, bus.shift_en, bus.win_valid, bus.busy,
                                         bus.done, bus.row, bus.col}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        a0 = acc_cnt; h0 = hs_cnt;
        pulse_start();
        wait_done("post-reset frame", 1300);
        chk("post-reset windows", hs_cnt - h0, 784);
        chk("post-reset shifts", acc_cnt - a0, 1024);

        // start pulses during LOAD and DRAIN are ignored.
        a0 = acc_cnt; h0 = hs_cnt;
        pulse_start();
        repeat (300) tick();
        pulse_start();
        for (int i = 0; i < 1500 && (acc_cnt - a0) != 1024; i++) tick();
        bus.win_ready = 1'b0;
        tick();
        chk("drain busy", int'(bus.busy), 1);
        pulse_start();
        bus.win_ready = 1'b1;
        wait_done("restart-ignored frame", 50);
        chk("restart-ignored windows", hs_cnt - h0, 784);
        chk("restart-ignored shifts", acc_cnt - a0, 1024);
`ifdef CONV_WIN_COUNT_EN
        tick();
        chk("win_cnt final", int'(bus.win_cnt), 784);
`endif
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencer for the LeNet5 convolution input stage.
- Accepts a raster-order pixel stream and drives the shared Enable of the register chain that forms the KxK sliding window and line buffers.
- Flags each cycle in which a complete window is present in that chain for the downstream MAC array.
- Applies backpressure to the pixel source while the MAC has not taken the current window.

Parameters:
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels.
- K, 5, kernel size; a window is complete when row >= K-1 and col >= K-1.
- CNT_W, 6, width of the row/col counters; must satisfy 2^CNT_W >= max(IMG_W, IMG_H).

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins a frame; ignored unless in IDLE.
- pix_valid, input, 1, source has a pixel on the datapath.
- pix_ready, output, 1, controller accepts a pixel this cycle.
- shift_en, output, 1, Enable to the window register chain; equals pix_valid & pix_ready (combinational).
- win_valid, output, 1, the register chain holds a complete window.
- win_ready, input, 1, MAC consumes the window this cycle.
- row, output, CNT_W, row index of the next pixel to be accepted.
- col, output, CNT_W, column index of the next pixel to be accepted.
- busy, output, 1, high in LOAD and DRAIN.
- done, output, 1, one-cycle pulse at end of frame.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, row=0, col=0; win_valid, done, busy, pix_ready and shift_en all 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE -> LOAD on start. Row and col are cleared on entry to LOAD.
- pix_ready = (state==LOAD) & (!win_valid | win_ready).
- A window is never overwritten before it is consumed: the chain shifts only when the pending window is taken in the same cycle.
- Accept = pix_valid & pix_ready. On accept:
  - shift_en=1 in the same cycle.
  - col increments. At col==IMG_W-1, col wraps to 0 and row increments.
- win_valid is registered.
  - Set in the cycle after an accept of pixel (r,c) with r>=K-1 and c>=K-1.
  - Cleared in the cycle after win_ready unless a new window is set in that same cycle; set has priority, so win_valid stays 1.
  - Held stable while win_ready=0.
- Column wrap: accepts of pixels with c<K-1 produce no window. The chain still shifts; no bubble is inserted.
- Last pixel: accept of (IMG_H-1, IMG_W-1) -> DRAIN; pix_ready=0 from then on.
- DRAIN -> DONE once win_valid=0, i.e. the last window has been consumed.
- DONE: done=1 for exactly one cycle, then IDLE. Row and col read 0 in DONE.
- start asserted in LOAD, DRAIN or DONE has no effect.
- pix_valid while in IDLE: ignored, no shift.
- Window count per frame is (IMG_H-K+1)*(IMG_W-K+1): 784 for the defaults.
- Reset mid-frame: immediate return to IDLE and all outputs cleared. The datapath chain contents are don't-care; the next frame refills them.
- Latency: pixel accept -> win_valid is 1 cycle.
- Throughput: 1 window per cycle when pix_valid=1 and win_ready=1 continuously.

Optional Feature:
- Macro: CONV_WIN_COUNT_EN.
- Defined:
  - Adds output win_cnt [15:0].
  - Cleared on reset and on IDLE->LOAD.
  - Increments on each win_valid & win_ready.
  - Holds its final value through DONE and IDLE until the next start.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then start, pix_valid=1 and win_ready=1 throughout (default params):
  - 1024 shift_en pulses and exactly 784 win_valid&win_ready cycles.
  - The first win_valid comes 1 cycle after the accept of pixel (4,4), i.e. the 133rd accept.
  - done pulses once, 2 cycles after the final accept.
- win_ready=0 for 10 cycles while win_valid=1:
  - pix_ready=0 and shift_en=0 for those cycles; win_valid stays 1.
  - When win_ready rises: pix_ready=1 and shift_en=1 in that same cycle.
- pix_valid toggling 1/0 each cycle: row/col advance only on accept cycles. After 64 accepts, row=2 and col=0.
- Assert reset=0 at accept #500 (row=15, col=19):
  - All outputs are 0 immediately, before the next clock edge; state is IDLE.
  - A new start runs a full 784-window frame.
- start pulsed in LOAD and DRAIN: no restart, no counter clear, window total still 784.
- CONV_WIN_COUNT_EN defined:
  - win_cnt=784 after done and holds through IDLE.
  - Next start clears win_cnt to 0.
